// File: rtl/mult_arb_pkg.sv
// Shared constants, FSM state type and round-robin pick helper for the
// multiplier-sharing arbiter.
package mult_arb_pkg;

    localparam int OP_W    = 16;
    localparam int PROD_W  = 32;
    localparam int MAX_REQ = 16;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        MUL  = 2'd1,
        RESP = 2'd2
    } mult_arb_state_t;

    typedef struct packed {
        logic       found;
        logic [3:0] idx;
    } rr_pick_t;

    // Scans nreq positions starting at ptr and returns the first valid index.
    function automatic rr_pick_t rr_pick(input logic [MAX_REQ-1:0] valid,
                                         input logic [3:0]         ptr,
                                         input int                 nreq);
        rr_pick_t r;
        int       idx;
        r = '0;
        for (int k = 0; k < MAX_REQ; k++) begin
            idx = (int'(ptr) + k) % nreq;
            if (k < nreq && !r.found && valid[idx]) begin
                r.found = 1'b1;
                r.idx   = 4'(idx);
            end
        end
        return r;
    endfunction

endpackage

// File: rtl/rr_arbiter.sv
// Combinational round-robin arbiter: one-hot grant for the first valid
// requester at or after ptr, suppressed when enable is low.
module rr_arbiter
    import mult_arb_pkg::*;
#(
    parameter int NREQ = 4,
    localparam int PW  = (NREQ > 1) ? $clog2(NREQ) : 1
) (
    input  logic [NREQ-1:0] valid,
    input  logic [PW-1:0]   ptr,
    input  logic            enable,
    output logic [NREQ-1:0] grant,
    output logic [PW-1:0]   grant_idx,
    output logic            found
);

    logic [MAX_REQ-1:0] valid_ext;
    rr_pick_t           pick;

    always_comb begin
        valid_ext             = '0;
        valid_ext[NREQ-1:0]   = valid;
        pick                  = rr_pick(valid_ext, 4'(ptr), NREQ);
        found                 = enable && pick.found;
        grant_idx             = PW'(pick.idx);
        grant                 = '0;
        if (found) begin
            grant[grant_idx] = 1'b1;
        end
    end

endmodule

// File: rtl/wallace_multiplier.sv
// Combinational unsigned 16x16 multiplier: partial products are reduced with
// 3:2 carry-save compressors and resolved by a single final addition.
module wallace_multiplier (
    input  logic [15:0] a,
    input  logic [15:0] b,
    output logic [31:0] p
);

    logic [31:0] pp [16];
    logic [31:0] s;
    logic [31:0] c;
    logic [31:0] s_n;

    always_comb begin
        for (int i = 0; i < 16; i++) begin
            pp[i] = b[i] ? (32'(a) << i) : 32'd0;
        end
        s   = pp[0];
        c   = pp[1];
        s_n = '0;
        // Carries out of bit 31 are dropped: the product always fits 32 bits.
        for (int i = 2; i < 16; i++) begin
            s_n = s ^ c ^ pp[i];
            c   = ((s & c) | (s & pp[i]) | (c & pp[i])) << 1;
            s   = s_n;
        end
        p = s + c;
    end

endmodule

// File: rtl/mult_share_arbiter.sv
// Shares one combinational multiplier among NREQ valid/ready requesters with
// round-robin grants and a single registered, id-tagged response channel.
module mult_share_arbiter
    import mult_arb_pkg::*;
#(
    parameter int NREQ = 4,
    parameter int IDW  = (NREQ > 1) ? $clog2(NREQ) : 1
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic [NREQ-1:0]      req_valid,
    input  logic [NREQ*OP_W-1:0] req_a,
    input  logic [NREQ*OP_W-1:0] req_b,
    output logic [NREQ-1:0]      req_ready,
    output logic                 resp_valid,
    input  logic                 resp_ready,
    output logic [IDW-1:0]       resp_id,
    output logic [PROD_W-1:0]    resp_prod,
    output logic                 busy
);

    localparam int PW = (NREQ > 1) ? $clog2(NREQ) : 1;

    mult_arb_state_t   state_q, state_d;
    logic [PW-1:0]     rr_ptr_q, rr_ptr_d;
    logic [OP_W-1:0]   op_a_q, op_a_d;
    logic [OP_W-1:0]   op_b_q, op_b_d;
    logic [PW-1:0]     op_id_q, op_id_d;
    logic [PROD_W-1:0] resp_prod_q, resp_prod_d;
    logic [IDW-1:0]    resp_id_q, resp_id_d;

    logic              accept_window;
    logic [NREQ-1:0]   grant;
    logic [PW-1:0]     grant_idx;
    logic              found;
    logic [PROD_W-1:0] mult_p;

    // Gating with rst keeps req_ready low for the whole reset pulse.
    assign accept_window = !rst && ((state_q == IDLE) || ((state_q == RESP) && resp_ready));

    rr_arbiter #(.NREQ(NREQ)) u_arb (
        .valid     (req_valid),
        .ptr       (rr_ptr_q),
        .enable    (accept_window),
        .grant     (grant),
        .grant_idx (grant_idx),
        .found     (found)
    );

    wallace_multiplier u_mult (
        .a (op_a_q),
        .b (op_b_q),
        .p (mult_p)
    );

    always_comb begin
        state_d     = state_q;
        rr_ptr_d    = rr_ptr_q;
        op_a_d      = op_a_q;
        op_b_d      = op_b_q;
        op_id_d     = op_id_q;
        resp_prod_d = resp_prod_q;
        resp_id_d   = resp_id_q;

        if (found) begin
            op_a_d   = req_a[int'(grant_idx)*OP_W +: OP_W];
            op_b_d   = req_b[int'(grant_idx)*OP_W +: OP_W];
            op_id_d  = grant_idx;
            rr_ptr_d = (grant_idx == PW'(NREQ - 1)) ? '0 : grant_idx + 1'b1;
        end

        case (state_q)
            IDLE: if (found) state_d = MUL;
            MUL: begin
                resp_prod_d = mult_p;
                resp_id_d   = IDW'(op_id_q);
                state_d     = RESP;
            end
            RESP: if (resp_ready) state_d = found ? MUL : IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= IDLE;
            rr_ptr_q    <= '0;
            op_a_q      <= '0;
            op_b_q      <= '0;
            op_id_q     <= '0;
            resp_prod_q <= '0;
            resp_id_q   <= '0;
        end else begin
            state_q     <= state_d;
            rr_ptr_q    <= rr_ptr_d;
            op_a_q      <= op_a_d;
            op_b_q      <= op_b_d;
            op_id_q     <= op_id_d;
            resp_prod_q <= resp_prod_d;
            resp_id_q   <= resp_id_d;
        end
    end

    assign req_ready  = grant;
    assign resp_valid = (state_q == RESP);
    assign busy       = (state_q != IDLE);
    assign resp_prod  = resp_prod_q;
    assign resp_id    = resp_id_q;

endmodule
